// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the programmable FIFO family.
//   FIFO_STD / FIFO_FWFT : read-mode encoding used for the FWFT parameter
//   ptr_w(depth)         : pointer width, $clog2(depth)
//   cnt_w(depth)         : fill-level width, ptr_w(depth)+1 (holds 0..depth)
//   is_pow2(v)           : true for powers of two >= 2
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int ptr_w(input int depth);
      // Guard keeps the width sane even for an illegal DEPTH so that the
      // parameter check is what reports the problem.
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return ptr_w(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_prog_mem.sv
// ---------------------------------------------------------------------------
// fifo_prog_mem
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are never reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data, mem[rd_addr]
// ---------------------------------------------------------------------------
module fifo_prog_mem #(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// ---------------------------------------------------------------------------
// fifo_prog
// Synchronous FIFO with power-of-two depth, standard or first-word-fall-
// through read, programmable almost-full/almost-empty, fill-level output and
// sticky overflow/underflow flags.
//   clk         : clock, rising edge
//   arst_n      : asynchronous active-low reset
//   srst        : synchronous clear, active-high, beats wr/rd/clr_err
//   wr, data    : write request and write data
//   rd          : read request (FWFT: pop of the head word)
//   clr_err     : synchronous clear of overflow/underflow
//   q           : read data (STD: registered; FWFT: head word while !mty)
//   count       : fill level 0..DEPTH
//   full, almost_full, mty, almost_mty : registered status from count
//   overflow    : sticky, write rejected because full
//   underflow   : sticky, read rejected because empty
// Handshake: a request is accepted on the edge where it is high and its
// accept term (wr_ok / rd_ok, computed from pre-edge state) is true; a
// rejected request changes nothing except the matching error flag.
// ---------------------------------------------------------------------------
module fifo_prog
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = FIFO_STD
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      srst,
   input  logic                      wr,
   input  logic                      rd,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic                      clr_err,
   output logic [DATA_WIDTH-1:0]     q,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      full,
   output logic                      almost_full,
   output logic                      mty,
   output logic                      almost_mty,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   generate
      if (!is_pow2(DEPTH) || DEPTH > 1024) begin : g_bad_depth
         $error("fifo_prog: DEPTH must be a power of two in 2..1024");
      end
      if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
         $error("fifo_prog: AF_THRESH must be in 1..DEPTH");
      end
      if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
         $error("fifo_prog: AE_THRESH must be in 0..DEPTH-1");
      end
      if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
         $error("fifo_prog: FWFT must be 0 or 1");
      end
   endgenerate

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, full_d;
   logic                  afull_q, afull_d;
   logic                  mty_q, mty_d;
   logic                  amty_q, amty_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_ok, rd_ok, mem_we;
   logic [DATA_WIDTH-1:0] rd_data;

   // A write at full is still taken when a read frees the slot this edge.
   assign rd_ok  = rd & ~mty_q;
   assign wr_ok  = wr & (~full_q | rd_ok);
   assign mem_we = wr_ok & ~srst;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (srst) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
         // Set beats clear when both happen in one cycle.
         if (clr_err)      ovf_d = 1'b0;
         if (wr && !wr_ok) ovf_d = 1'b1;
         if (clr_err)      udf_d = 1'b0;
         if (rd && !rd_ok) udf_d = 1'b1;
      end
      // Status flags are registered from count_d so they line up with count.
      full_d  = (count_d == CNT_W'(DEPTH));
      afull_d = (count_d >= CNT_W'(AF_THRESH));
      mty_d   = (count_d == '0);
      amty_d  = (count_d <= CNT_W'(AE_THRESH));
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         mty_q    <= 1'b1;
         amty_q   <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         mty_q    <= mty_d;
         amty_q   <= amty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_prog_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (wr_ptr_q),
      .wr_data (data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   generate
      if (FWFT == FIFO_FWFT) begin : g_fwft
         // Head word is shown directly; meaningless while mty is high.
         assign q = rd_data;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] q_q, q_d;

         always_comb begin
            q_d = q_q;
            if (srst)       q_d = '0;
            else if (rd_ok) q_d = rd_data;
         end

         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) q_q <= '0;
            else         q_q <= q_d;
         end

         assign q = q_q;
      end
   endgenerate

   assign count       = count_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign mty         = mty_q;
   assign almost_mty  = amty_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

endmodule

// File: tb/tb_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_fifo_prog
// Directed bench for fifo_prog: one standard-mode and one FWFT instance share
// the same stimulus; each section checks the instance it is about.
// ---------------------------------------------------------------------------
module tb_fifo_prog;

   localparam int DW = 128;

   logic          clk;
   logic          arst_n;
   logic          srst;
   logic          wr;
   logic          rd;
   logic [DW-1:0] data;
   logic          clr_err;

   logic [DW-1:0] s_q, f_q;
   logic [3:0]    s_count, f_count;
   logic          s_full, s_afull, s_mty, s_amty, s_ovf, s_udf;
   logic          f_full, f_afull, f_mty, f_amty, f_ovf, f_udf;

   int n_checks;
   int n_fail;

   logic [DW-1:0] exp_q[$];

   fifo_prog #(.DATA_WIDTH(DW), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut_std (
      .clk (clk), .arst_n (arst_n), .srst (srst), .wr (wr), .rd (rd), .data (data),
      .clr_err (clr_err), .q (s_q), .count (s_count), .full (s_full),
      .almost_full (s_afull), .mty (s_mty), .almost_mty (s_amty),
      .overflow (s_ovf), .underflow (s_udf)
   );

   fifo_prog #(.DATA_WIDTH(DW), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_fwft (
      .clk (clk), .arst_n (arst_n), .srst (srst), .wr (wr), .rd (rd), .data (data),
      .clr_err (clr_err), .q (f_q), .count (f_count), .full (f_full),
      .almost_full (f_afull), .mty (f_mty), .almost_mty (f_amty),
      .overflow (f_ovf), .underflow (f_udf)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cycle(input logic w, input logic r, input logic [DW-1:0] d);
      wr   = w;
      rd   = r;
      data = d;
      step();
      wr   = 1'b0;
      rd   = 1'b0;
   endtask

   task automatic check_std_reset(input string tag);
      check({tag, "_count"}, s_count, 0);
      check({tag, "_mty"},   s_mty,   1);
      check({tag, "_amty"},  s_amty,  1);
      check({tag, "_full"},  s_full,  0);
      check({tag, "_afull"}, s_afull, 0);
      check({tag, "_ovf"},   s_ovf,   0);
      check({tag, "_udf"},   s_udf,   0);
      check({tag, "_q"},     s_q,     0);
      check({tag, "_fcount"}, f_count, 0);
      check({tag, "_fmty"},   f_mty,   1);
   endtask

   logic [DW-1:0] exp_word;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      arst_n   = 1'b0;
      srst     = 1'b0;
      wr       = 1'b0;
      rd       = 1'b0;
      data     = '0;
      clr_err  = 1'b0;
      #12;
      check_std_reset("rst");
      arst_n = 1'b1;
      step();

      // Fill 0x01..0x08, watching thresholds (AF=6, AE=2).
      for (int i = 1; i <= 8; i++) begin
         do_cycle(1'b1, 1'b0, DW'(i));
         check("fill_count", s_count, DW'(i));
         check("fill_afull", s_afull, (i >= 6) ? 1 : 0);
         check("fill_amty",  s_amty,  (i <= 2) ? 1 : 0);
      end
      check("fill_full", s_full, 1);

      // Write while full: rejected.
      do_cycle(1'b1, 1'b0, 'hFF);
      check("ovf_count", s_count, 8);
      check("ovf_flag",  s_ovf,   1);
      check("ovf_full",  s_full,  1);

      // Drain: q shows each word one cycle after rd.
      for (int i = 1; i <= 8; i++) begin
         do_cycle(1'b0, 1'b1, '0);
         check("drain_q",     s_q,     DW'(i));
         check("drain_count", s_count, DW'(8 - i));
         check("drain_afull", s_afull, ((8 - i) >= 6) ? 1 : 0);
         check("drain_amty",  s_amty,  ((8 - i) <= 2) ? 1 : 0);
      end
      check("drain_mty", s_mty, 1);

      // Read while empty: rejected, q holds.
      do_cycle(1'b0, 1'b1, '0);
      check("udf_flag",  s_udf,   1);
      check("udf_q",     s_q,     8);
      check("udf_count", s_count, 0);

      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("clr_ovf", s_ovf, 0);
      check("clr_udf", s_udf, 0);

      // wr & rd at empty: read rejected, write taken.
      do_cycle(1'b1, 1'b1, 'h11);
      check("wrrd_mty_udf",   s_udf,   1);
      check("wrrd_mty_count", s_count, 1);
      check("wrrd_mty_q",     s_q,     8);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;

      // Fill to full, then wr & rd at full.
      for (int i = 2; i <= 8; i++) do_cycle(1'b1, 1'b0, DW'('h10 + i));
      check("wrrd_full_pre", s_count, 8);
      do_cycle(1'b1, 1'b1, 'h19);
      check("wrrd_full_count", s_count, 8);
      check("wrrd_full_full",  s_full,  1);
      check("wrrd_full_ovf",   s_ovf,   0);
      check("wrrd_full_q",     s_q,     'h11);
      for (int i = 2; i <= 9; i++) begin
         do_cycle(1'b0, 1'b1, '0);
         check("wrrd_full_order", s_q, DW'('h10 + i));
      end
      check("wrrd_full_end", s_count, 0);

      // Wrap: preload 3, then 20 cycles of simultaneous wr & rd.
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         do_cycle(1'b1, 1'b0, DW'('h30 + i));
         exp_q.push_back(DW'('h30 + i));
      end
      for (int k = 0; k < 20; k++) begin
         exp_word = exp_q.pop_front();
         exp_q.push_back(DW'('h40 + k));
         do_cycle(1'b1, 1'b1, DW'('h40 + k));
         check("wrap_q", s_q, exp_word);
         check("wrap_count", s_count, 3);
      end
      // Fill to full and overflow, then reset asynchronously mid-cycle.
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, DW'('h60 + i));
      do_cycle(1'b1, 1'b0, 'h7F);
      check("pre_arst_ovf",   s_ovf,   1);
      check("pre_arst_count", s_count, 8);
      wr = 1'b1;
      rd = 1'b1;
      #2;
      arst_n = 1'b0;
      #1;
      check_std_reset("arst");
      wr = 1'b0;
      rd = 1'b0;
      #2;
      arst_n = 1'b1;
      step();

      // srst: empty read, 3 writes, 1 read, then srst with everything high.
      do_cycle(1'b0, 1'b1, '0);
      for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, DW'('h80 + i));
      do_cycle(1'b0, 1'b1, '0);
      check("pre_srst_q",   s_q,     'h80);
      check("pre_srst_udf", s_udf,   1);
      srst    = 1'b1;
      clr_err = 1'b0;
      do_cycle(1'b1, 1'b1, 'h99);
      srst = 1'b0;
      check_std_reset("srst");

      // FWFT instance: head word visible one cycle after write.
      do_cycle(1'b1, 1'b0, 'hA5);
      check("fwft_mty",   f_mty, 0);
      check("fwft_q1",    f_q,   'hA5);
      do_cycle(1'b1, 1'b0, 'h5A);
      check("fwft_hold",  f_q,     'hA5);
      check("fwft_cnt2",  f_count, 2);
      do_cycle(1'b0, 1'b1, '0);
      check("fwft_q2",    f_q,     'h5A);
      check("fwft_cnt1",  f_count, 1);
      do_cycle(1'b0, 1'b1, '0);
      check("fwft_empty", f_mty,   1);
      do_cycle(1'b0, 1'b1, '0);
      check("fwft_udf",   f_udf,   1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
